// File: rtl/prbs4_pkg.sv
// Shared definitions for the 4-bit PRBS pattern generator / checker pair.
// Sequence law: s[n] = s[n-1] ^ s[n-4], seed 4'b1000, period 15.
// History registers are ordered with the newest bit in [0], the oldest in [PRBS_W-1].
package prbs4_pkg;

    localparam int unsigned PRBS_W      = 4;
    localparam int unsigned PRBS_PERIOD = 15;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 4'b1000;

    // Tap positions inside a history register (newest, oldest)
    localparam int unsigned TAP_NEW = 0;
    localparam int unsigned TAP_OLD = PRBS_W - 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    // Next bit of the sequence given the last PRBS_W bits
    function automatic logic prbs_predict(input logic [PRBS_W-1:0] hist);
        return hist[TAP_NEW] ^ hist[TAP_OLD];
    endfunction

    // Advance a history register by one bit of the sequence
    function automatic logic [PRBS_W-1:0] prbs_advance(input logic [PRBS_W-1:0] hist);
        return {hist[PRBS_W-2:0], prbs_predict(hist)};
    endfunction

endpackage : prbs4_pkg

// File: rtl/prbs4_checker.sv
// PRBS4 receive checker: self-synchronises to the serial out[4] stream of the
// 4-bit LFSR generator, reports lock, and counts bit errors against a
// free-running local reference.
//
// Ports:
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset
//   in_valid  in_bit is valid this cycle (idle cycles allowed anywhere)
//   in_bit    received serial bit
//   cnt_clr   synchronous clear of err_cnt (wins over an increment)
//   locked    checker is in the LOCKED state
//   err       one-cycle pulse: last valid bit mismatched while LOCKED
//   err_cnt   saturating count of mismatches seen while LOCKED
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned MATCH_W = 8;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned FILL_W  = 3;

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(PRBS_W);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    prbs_state_e         state_q, state_d;
    logic [PRBS_W-1:0]   hist_q,  hist_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [MISS_W-1:0]   miss_q,  miss_d;
    logic                err_q,   err_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    logic                exp_c;
    logic                mismatch_c;
    logic                hist_zero_c;

    assign exp_c       = prbs_predict(hist_q);
    assign mismatch_c  = in_bit ^ exp_c;
    assign hist_zero_c = (hist_q == '0);

    // Next-state: search/lock control, history shifter, error accounting
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (in_valid) begin
            if (state_q == SEARCH) begin
                hist_d = {hist_q[PRBS_W-2:0], in_bit};
                if (fill_q < FILL_FULL) begin
                    fill_d = fill_q + FILL_W'(1);
                end else if (!mismatch_c && !hist_zero_c) begin
                    // all-zero history is the lock-up state and never counts
                    if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                // flywheel on the prediction so one flipped bit costs one error
                hist_d = {hist_q[PRBS_W-2:0], exp_c};
                if (mismatch_c) begin
                    err_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (miss_q == MISS_LAST) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule : prbs4_checker

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
- Receive-side companion to the team's 4-bit LFSR pattern generator: feedback out[1]^out[4], seed 4'b1000, period 15.
- Consumes the generator's out[4] bit serially, self-synchronises to the sequence and reports lock.
- Counts bit errors against a free-running local reference.
- Sits at the far end of a loopback or board link as a link/BER test block.

Parameters:
LOCK_CNT, 8, consecutive correct predictions in SEARCH required to declare lock (1..255)
UNLOCK_CNT, 3, consecutive mispredictions in LOCKED that drop lock (1..15)
CNT_W, 16, width of the error counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
in_valid  input  1  in_bit is valid this cycle; idle cycles allowed anywhere
in_bit  input  1  received serial bit (the generator's out[4], one per valid cycle)
cnt_clr  input  1  synchronous clear of err_cnt
locked  output  1  checker is in LOCKED state (registered)
err  output  1  one-cycle pulse: the last valid bit mismatched while LOCKED (registered)
err_cnt  output  CNT_W  saturating count of mismatches seen while LOCKED

Behaviour:
- Reset (async, RST=1):
  - state=SEARCH, history h=4'b0000, fill=0, match_cnt=0, miss_cnt=0.
  - Outputs: locked=0, err=0, err_cnt=0.
- Sequence law: serial stream obeys s[n] = s[n-1] ^ s[n-4].
  - History h holds the last 4 bits.
  - Prediction exp = h_newest ^ h_oldest.
  - Reference stream from seed: 000111101011001, repeating.
- in_valid=0:
  - No state, history or counter change.
  - err=0 next cycle.
- SEARCH:
  - Every valid bit shifts in_bit into h.
  - While fill<4: fill increments, no comparison.
  - Once fill=4, each valid bit is compared with exp:
    - Match with h nonzero: match_cnt+1.
    - Otherwise: match_cnt=0.
  - An all-zero h never counts as a match, so the all-zero lock-up stream never locks.
  - On the valid bit that makes match_cnt reach LOCK_CNT: state=LOCKED, so locked=1 on the following cycle.
  - Minimum lock latency on a clean stream: 4+LOCK_CNT valid bits.
- LOCKED:
  - exp (not in_bit) is shifted into h, so h runs as a local generator and one flipped bit gives exactly one error.
  - Mismatch (in_bit != exp):
    - err=1 next cycle.
    - err_cnt+1, saturating at 2^CNT_W-1.
    - miss_cnt+1.
  - Match: miss_cnt=0.
  - On the mismatch that makes miss_cnt reach UNLOCK_CNT:
    - state=SEARCH; fill, match_cnt and miss_cnt cleared.
    - locked=0 next cycle.
    - That mismatch is still counted and pulses err.
  - err_cnt is retained across lock loss and relock.
- cnt_clr:
  - err_cnt=0 next cycle.
  - Wins over a simultaneous increment; err pulse still occurs.
- RST asserted mid-stream: immediate return to reset values; no partial state survives.
- No other outputs; err is never asserted in SEARCH.

Decomposition:
- Shared package prbs4_pkg:
  - PRBS_W=4, PRBS_SEED=4'b1000, PRBS_PERIOD=15.
  - State encoding SEARCH=1'b0, LOCKED=1'b1.
  - Tap positions (newest, oldest).
- The package is reused by the generator side.
- Block stays flat; no sub-module is natural (predictor is a single XOR, history a 4-bit shifter).

Test Plan:
- Reset: hold RST=1 for 3 cycles with random in_bit -> locked=0, err=0, err_cnt=0 throughout; release -> no change until valid bits arrive.
- Clean lock: stream 000111101011001 repeated, in_valid=1 every cycle, LOCK_CNT=8 -> locked rises the cycle after the 12th bit; after 60 further bits err_cnt=0, err never high.
- Single error: after lock, flip one bit -> err high exactly one cycle, err_cnt=1, locked stays 1, next 30 bits clean with no further err.
- Lock loss and relock:
  - After lock, invert 3 consecutive bits -> err_cnt=3, locked falls the cycle after the 3rd.
  - Clean stream resumes -> locked returns after 12 valid bits; err_cnt stays 3.
- All-zero stream: 40 valid zeros from reset -> locked never asserts, err_cnt=0.
- Gaps and clear:
  - Repeat clean lock with in_valid toggled pseudo-randomly (about 50% idle) -> identical lock point in valid-bit count.
  - Then cnt_clr=1 on the same cycle as a flipped bit -> err pulses, err_cnt=0.
